// File: rtl/axi_lite_regs_pkg.sv
// rtl/axi_lite_regs_pkg.sv - shared response codes and FSM state types for the AXI-Lite register slave
package axi_lite_regs_pkg;
  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;
endpackage

// File: rtl/axi_lite_regs_bank.sv
// rtl/axi_lite_regs_bank.sv - register storage with byte-strobe writes and per-register write pulses
module axi_lite_regs_bank #(
  parameter int                               DATA_WIDTH = 32,
  parameter int                               NUM_REGS   = 8,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RESET_VAL  = '0,
  parameter int                               IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           wr_en_i,
  input  logic [IDX_W-1:0]               wr_idx_i,
  input  logic [DATA_WIDTH-1:0]          wr_data_i,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_d, regs_q;
  logic [NUM_REGS-1:0]            pulse_d, pulse_q;

  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    if (wr_en_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx_i == IDX_W'(i)) begin
          for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (wr_strb_i[b]) regs_d[i*DATA_WIDTH + b*8 +: 8] = wr_data_i[b*8 +: 8];
          end
          // A write with no strobed bytes changes nothing, so it is not announced.
          pulse_d[i] = |wr_strb_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q  <= RESET_VAL;
      pulse_q <= '0;
    end else begin
      regs_q  <= regs_d;
      pulse_q <= pulse_d;
    end
  end

  assign reg_q_o    = regs_q;
  assign wr_pulse_o = pulse_q;
endmodule

// File: rtl/axi_lite_regs_slave.sv
// rtl/axi_lite_regs_slave.sv - AXI-Lite slave with independent write/read FSMs; AXI_LITE_REGS_SLVERR_EN enables SLVERR on out-of-range
module axi_lite_regs_slave
  import axi_lite_regs_pkg::*;
#(
  parameter int                             ADDR_WIDTH = 32,
  parameter int                             DATA_WIDTH = 32,
  parameter int                             NUM_REGS   = 8,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [ADDR_WIDTH-1:0]          aw_addr_i,
  input  logic                           aw_valid_i,
  output logic                           aw_ready_o,
  input  logic [DATA_WIDTH-1:0]          w_data_i,
  input  logic [DATA_WIDTH/8-1:0]        w_strb_i,
  input  logic                           w_valid_i,
  output logic                           w_ready_o,
  output logic [1:0]                     b_resp_o,
  output logic                           b_valid_o,
  input  logic                           b_ready_i,
  input  logic [ADDR_WIDTH-1:0]          ar_addr_i,
  input  logic                           ar_valid_i,
  output logic                           ar_ready_o,
  output logic [DATA_WIDTH-1:0]          r_data_o,
  output logic [1:0]                     r_resp_o,
  output logic                           r_valid_o,
  input  logic                           r_ready_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);
  localparam int OFFS   = $clog2(DATA_WIDTH/8);
  localparam int WIDX_W = ADDR_WIDTH - OFFS;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [WIDX_W-1:0] NUM_REGS_W = WIDX_W'(NUM_REGS);
`ifdef AXI_LITE_REGS_SLVERR_EN
  localparam resp_t OOR_RESP = RESP_SLVERR;
`else
  localparam resp_t OOR_RESP = RESP_OKAY;
`endif

  w_state_e                w_state_d, w_state_q;
  logic                    aw_seen_d, aw_seen_q, w_seen_d, w_seen_q;
  logic [WIDX_W-1:0]       aw_idx_d, aw_idx_q;
  logic [DATA_WIDTH-1:0]   w_data_d, w_data_q;
  logic [DATA_WIDTH/8-1:0] w_strb_d, w_strb_q;
  resp_t                   b_resp_d, b_resp_q;
  r_state_e                r_state_d, r_state_q;
  logic [DATA_WIDTH-1:0]   r_data_d, r_data_q;
  resp_t                   r_resp_d, r_resp_q;

  logic                    aw_rdy, w_rdy, aw_hs, w_hs, wr_en;
  logic [WIDX_W-1:0]       cm_idx, ar_idx;
  logic [DATA_WIDTH-1:0]   cm_data, rd_word;
  logic [DATA_WIDTH/8-1:0] cm_strb;
  logic                    cm_in_range, rd_in_range;
  logic                    unused_addr_lsbs;

  assign unused_addr_lsbs = ^{aw_addr_i[OFFS-1:0], ar_addr_i[OFFS-1:0]};

  // The commit uses whichever half is already latched, otherwise the live bus.
  assign cm_idx      = aw_seen_q ? aw_idx_q : aw_addr_i[ADDR_WIDTH-1:OFFS];
  assign cm_data     = w_seen_q ? w_data_q : w_data_i;
  assign cm_strb     = w_seen_q ? w_strb_q : w_strb_i;
  assign cm_in_range = cm_idx < NUM_REGS_W;
  assign ar_idx      = ar_addr_i[ADDR_WIDTH-1:OFFS];
  assign rd_in_range = ar_idx < NUM_REGS_W;

  always_comb begin
    w_state_d = w_state_q;
    aw_seen_d = aw_seen_q;
    w_seen_d  = w_seen_q;
    aw_idx_d  = aw_idx_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    b_resp_d  = b_resp_q;
    aw_rdy    = 1'b0;
    w_rdy     = 1'b0;
    wr_en     = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_rdy = !aw_seen_q;
        w_rdy  = !w_seen_q;
        aw_hs  = aw_valid_i && aw_rdy;
        w_hs   = w_valid_i && w_rdy;
        if ((aw_seen_q || aw_hs) && (w_seen_q || w_hs)) begin
          wr_en     = cm_in_range;
          b_resp_d  = cm_in_range ? RESP_OKAY : OOR_RESP;
          aw_seen_d = 1'b0;
          w_seen_d  = 1'b0;
          w_state_d = W_RESP;
        end else begin
          if (aw_hs) begin
            aw_seen_d = 1'b1;
            aw_idx_d  = aw_addr_i[ADDR_WIDTH-1:OFFS];
          end
          if (w_hs) begin
            w_seen_d = 1'b1;
            w_data_d = w_data_i;
            w_strb_d = w_strb_i;
          end
        end
      end
      W_RESP: if (b_ready_i) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Reads see the registered contents, so a same-cycle write is not visible yet.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == WIDX_W'(i)) rd_word = reg_q_o[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    case (r_state_q)
      R_IDLE: if (ar_valid_i) begin
        r_state_d = R_RESP;
        r_data_d  = rd_word;
        r_resp_d  = rd_in_range ? RESP_OKAY : OOR_RESP;
      end
      R_RESP: if (r_ready_i) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      aw_seen_q <= 1'b0;
      w_seen_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_resp_q  <= RESP_OKAY;
      r_state_q <= R_IDLE;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_seen_q <= aw_seen_d;
      w_seen_q  <= w_seen_d;
      aw_idx_q  <= aw_idx_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_resp_q  <= b_resp_d;
      r_state_q <= r_state_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
    end
  end

  assign aw_ready_o = aw_rdy;
  assign w_ready_o  = w_rdy;
  assign b_valid_o  = (w_state_q == W_RESP);
  assign b_resp_o   = b_resp_q;
  assign ar_ready_o = (r_state_q == R_IDLE);
  assign r_valid_o  = (r_state_q == R_RESP);
  assign r_data_o   = r_data_q;
  assign r_resp_o   = r_resp_q;

  axi_lite_regs_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RESET_VAL  (RESET_VAL),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (wr_en),
    .wr_idx_i   (cm_idx[IDX_W-1:0]),
    .wr_data_i  (cm_data),
    .wr_strb_i  (cm_strb),
    .reg_q_o    (reg_q_o),
    .wr_pulse_o (wr_pulse_o)
  );
endmodule

// File: tb/tb_axi_lite_regs_slave.sv
// tb/tb_axi_lite_regs_slave.sv - directed and randomized bench for axi_lite_regs_slave against a register-array model
module tb_axi_lite_regs_slave;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   aw_addr, w_data, ar_addr, r_data;
  logic [3:0]    w_strb;
  logic          aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic          ar_valid, ar_ready, r_valid, r_ready;
  logic [1:0]    b_resp, r_resp;
  logic [255:0]  reg_q;
  logic [7:0]    wr_pulse;

  int            tests = 0;
  int            fails = 0;
  logic [31:0]   model [NR];
`ifdef AXI_LITE_REGS_SLVERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  always #5 clk = ~clk;

  axi_lite_regs_slave dut (
    .clk_i(clk), .rst_i(rst),
    .aw_addr_i(aw_addr), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready),
    .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
    .ar_addr_i(ar_addr), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
    .r_data_o(r_data), .r_resp_o(r_resp), .r_valid_o(r_valid), .r_ready_i(r_ready),
    .reg_q_o(reg_q), .wr_pulse_o(wr_pulse)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] model_vec();
    logic [255:0] v;
    for (int i = 0; i < NR; i++) v[i*32 +: 32] = model[i];
    return v;
  endfunction

  // mode 0: AW and W together; 1: W leads by gap cycles; 2: AW leads by gap cycles
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int mode, input int gap, input int hold);
    int         idx;
    logic       in_r;
    logic [1:0] er;
    logic [7:0] ep;
    idx  = int'(addr >> 2);
    in_r = idx < NR;
    er   = in_r ? 2'b00 : OOR;
    ep   = (in_r && strb != 4'h0) ? (8'h01 << idx) : 8'h00;
    if (mode == 1) begin
      w_data = data; w_strb = strb; w_valid = 1'b1;
      chk("w_ready_first", w_ready, 1'b1);
      step(); w_valid = 1'b0;
      repeat (gap - 1) begin
        chk("gap_aw_ready", aw_ready, 1'b1); chk("gap_w_ready", w_ready, 1'b0);
        step();
      end
      chk("gap_aw_ready", aw_ready, 1'b1); chk("gap_w_ready", w_ready, 1'b0);
      aw_addr = addr; aw_valid = 1'b1;
      step(); aw_valid = 1'b0;
    end else if (mode == 2) begin
      aw_addr = addr; aw_valid = 1'b1;
      chk("aw_ready_first", aw_ready, 1'b1);
      step(); aw_valid = 1'b0;
      repeat (gap - 1) begin
        chk("gap_w_ready", w_ready, 1'b1); chk("gap_aw_ready", aw_ready, 1'b0);
        step();
      end
      chk("gap_w_ready", w_ready, 1'b1); chk("gap_aw_ready", aw_ready, 1'b0);
      w_data = data; w_strb = strb; w_valid = 1'b1;
      step(); w_valid = 1'b0;
    end else begin
      aw_addr = addr; aw_valid = 1'b1; w_data = data; w_strb = strb; w_valid = 1'b1;
      chk("aw_ready_idle", aw_ready, 1'b1); chk("w_ready_idle", w_ready, 1'b1);
      step(); aw_valid = 1'b0; w_valid = 1'b0;
    end
    if (in_r) for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
    chk("b_valid", b_valid, 1'b1);
    chk("b_resp", b_resp, er);
    chk("wr_pulse", wr_pulse, ep);
    chk("reg_q", reg_q, model_vec());
    repeat (hold) begin
      step();
      chk("hold_b_valid", b_valid, 1'b1); chk("hold_b_resp", b_resp, er);
      chk("hold_aw_ready", aw_ready, 1'b0); chk("hold_w_ready", w_ready, 1'b0);
      chk("hold_pulse", wr_pulse, 8'h00);
    end
    b_ready = 1'b1; step(); b_ready = 1'b0;
    chk("b_done", b_valid, 1'b0);
    chk("ready_back", {aw_ready, w_ready}, 2'b11);
    chk("pulse_off", wr_pulse, 8'h00);
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold);
    int          idx;
    logic [31:0] ed;
    logic [1:0]  er;
    idx = int'(addr >> 2);
    ed  = (idx < NR) ? model[idx] : 32'h0;
    er  = (idx < NR) ? 2'b00 : OOR;
    ar_addr = addr; ar_valid = 1'b1;
    chk("ar_ready", ar_ready, 1'b1);
    step(); ar_valid = 1'b0;
    chk("r_valid", r_valid, 1'b1);
    chk("r_data", r_data, ed);
    chk("r_resp", r_resp, er);
    repeat (hold) begin
      step();
      chk("hold_r_valid", r_valid, 1'b1); chk("hold_r_data", r_data, ed);
      chk("hold_r_resp", r_resp, er); chk("hold_ar_ready", ar_ready, 1'b0);
    end
    r_ready = 1'b1; step(); r_ready = 1'b0;
    chk("r_done", r_valid, 1'b0);
    chk("ar_ready_back", ar_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] nv;
    rst = 1'b1;
    aw_addr = '0; aw_valid = 1'b0; w_data = '0; w_strb = '0; w_valid = 1'b0; b_ready = 1'b0;
    ar_addr = '0; ar_valid = 1'b0; r_ready = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    step(); step();
    rst = 1'b0;

    chk("rst_readies", {aw_ready, w_ready, ar_ready}, 3'b111);
    chk("rst_valids", {b_valid, r_valid}, 2'b00);
    chk("rst_resps", {b_resp, r_resp}, 4'h0);
    chk("rst_r_data", r_data, 32'h0);
    chk("rst_pulse", wr_pulse, 8'h00);
    chk("rst_regs", reg_q, 256'h0);

    for (int i = 0; i < NR; i++) do_read(32'(i * 4), 0);

    do_write(32'h8, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(32'h8, 0);

    do_write(32'h4, 32'h12345678, 4'hF, 0, 0, 0);
    do_write(32'h4, 32'h0000AAAA, 4'b0011, 1, 2, 0);
    chk("reg1_merge", reg_q[63:32], 32'h1234AAAA);

    do_write(32'h10, $urandom, 4'hF, 2, 3, 5);
    do_read(32'h10, 5);

    do_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_read(32'h40, 0);
    do_write(32'h14, 32'hCAFE0000, 4'h0, 0, 0, 0);

    do_write(32'hC, 32'h1, 4'hF, 0, 0, 0);
    nv = $urandom;
    ar_addr = 32'hC; ar_valid = 1'b1;
    aw_addr = 32'hC; aw_valid = 1'b1; w_data = nv; w_strb = 4'hF; w_valid = 1'b1;
    step();
    ar_valid = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
    model[3] = nv;
    chk("rw_same_r_data", r_data, 32'h1);
    chk("rw_same_b_valid", b_valid, 1'b1);
    chk("rw_same_reg", reg_q[127:96], nv);
    chk("rw_same_pulse", wr_pulse, 8'h08);
    b_ready = 1'b1; r_ready = 1'b1; step(); b_ready = 1'b0; r_ready = 1'b0;

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 11) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        do_read(a, int'($urandom_range(0, 3)));
      else
        do_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 2)),
                 int'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
    end

    aw_addr = 32'h0; aw_valid = 1'b1; w_data = 32'h55AA55AA; w_strb = 4'hF; w_valid = 1'b1;
    step();
    aw_valid = 1'b0; w_valid = 1'b0;
    chk("pre_rst_b_valid", b_valid, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_b_valid", b_valid, 1'b0);
    chk("mid_rst_readies", {aw_ready, w_ready, ar_ready}, 3'b111);
    chk("mid_rst_regs", reg_q, 256'h0);
    chk("mid_rst_pulse", wr_pulse, 8'h00);
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    do_read(32'h0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
